rect_stream_tx: RTL
===================

RECT_STREAM_TX -- requirements
Module: rect_stream_tx

Interface
REQ-001 Parameter RECT_COUNT, default 64, number of rects streamed per frame.
REQ-002 Parameter RECT_COUNT_WIDTH, default 6, width of the rect index counter.
REQ-003 Parameter RECT_BASE, default 16'h0000, data-memory address of rect 0's record.
REQ-004 Port clk  input  1  sole clock, all state on posedge.
REQ-005 Port reset  input  1  asynchronous, active-low reset.
REQ-006 Port start  input  1  frame trigger, e.g. vsync, sampled only in IDLE.
REQ-007 Port mem_addr  output  16  data-memory read address; read latency is 1 cycle.
REQ-008 Port mem_din  input  16  read data for the address presented the previous cycle.
REQ-009 Port copy_start  output  1  one-cycle pulse telling the GPU to enter its copy phase.
REQ-010 Port dout  output  16  streamed absolute rect word to the GPU.
REQ-011 Port dout_valid  output  1  dout carries a stream word this cycle.
REQ-012 Port busy  output  1  high from START through the last stream word.

Function
REQ-013 Source record per rect, 5 consecutive words at RECT_BASE+5*i: x, y, width, height, color.
REQ-014 Stream order per rect i, i = 0..RECT_COUNT-1: left=x, top=y, right=x+width, bottom=y+height, color; total 5*RECT_COUNT words (320 at default).
REQ-015 States IDLE, START, STREAM, DONE: IDLE->START on start=1; START->STREAM unconditionally; STREAM->DONE after the last read is issued; DONE->IDLE once the last word has left dout.
REQ-016 Let the START cycle be C; copy_start=1 only in C, and mem_addr=RECT_BASE in C.
REQ-017 mem_addr increments by 1 each cycle from C to C+5*RECT_COUNT-1, with no gaps.
REQ-018 Stream word k is registered and valid on dout with dout_valid=1 exactly in cycle C+2+k, with no gaps.
REQ-019 left and top are latched when their words arrive and held so that right and bottom are formed without re-reading memory.
REQ-020 Without RECT_CLIP_EN, right and bottom are 16-bit sums that wrap modulo 2^16.
REQ-021 dout=0 and dout_valid=0 whenever no stream word is valid.
REQ-022 start asserted in START, STREAM or DONE is ignored, with no queuing.
REQ-023 start held high continuously retriggers one cycle after DONE->IDLE.
REQ-024 mem_addr holds its last value outside START and STREAM.

Reset
REQ-025 Reset asserted (low) at any time, including mid-stream, forces IDLE asynchronously; the frame is abandoned with no resume.
REQ-026 Reset values: copy_start=0, dout=0, dout_valid=0, busy=0, mem_addr=RECT_BASE, counters=0.

Configuration
REQ-027 Macro RECT_CLIP_EN: when defined, right and bottom saturate to 16'hFFFF on unsigned carry-out.
REQ-028 When RECT_CLIP_EN is undefined, no saturation logic is compiled and REQ-020 applies.

Structure
REQ-029 Shared package holds the state enum, RECTS_WORDS=5 and the field-offset constants (X=0, Y=1, W=2, H=3, COLOR=4).
REQ-030 Sub-module rect_abs_adder contains the adder for right/bottom and its optional saturation.
REQ-031 The rest (FSM, address counter, field counter 0..4, output register) is inline.

Verification
REQ-032 Pulse start in IDLE with rect 0 = {10,20,30,40,16'hF800} -> copy_start one cycle, then dout at C+2..C+6 = 10,20,40,60,16'hF800.
REQ-033 Full frame of 64 rects -> exactly 320 consecutive valid words, mem_addr RECT_BASE..RECT_BASE+319, busy deasserts after word 319.
REQ-034 x=16'hFFF0, width=16'h0020 -> right=16'h0010 without RECT_CLIP_EN; right=16'hFFFF with it.
REQ-035 Pulse start during STREAM at word 100 -> no effect; stream completes unchanged, with a single copy_start.
REQ-036 Drop reset at word 150 -> same-cycle outputs 0 and IDLE; next start yields a complete frame from rect 0.
REQ-037 Hold start high across two frames -> second copy_start one cycle after DONE->IDLE, with both frames intact.

Source files
------------

// File: rtl/rect_stream_tx_pkg.sv
// Shared types and constants for the rect streamer: FSM states and record layout.
package rect_stream_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int RECTS_WORDS = 5;

    localparam logic [2:0] FLD_X     = 3'd0;
    localparam logic [2:0] FLD_Y     = 3'd1;
    localparam logic [2:0] FLD_W     = 3'd2;
    localparam logic [2:0] FLD_H     = 3'd3;
    localparam logic [2:0] FLD_COLOR = 3'd4;

endpackage

// File: rtl/rect_stream_tx_adder.sv
// Forms right = left + width and bottom = top + height.
// Build macro RECT_CLIP_EN: saturate to 16'hFFFF on carry-out instead of wrapping.
module rect_abs_adder (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] sum_o
);

`ifdef RECT_CLIP_EN
    logic [16:0] sum_full;

    assign sum_full = {1'b0, a_i} + {1'b0, b_i};
    assign sum_o    = sum_full[16] ? 16'hFFFF : sum_full[15:0];
`else
    assign sum_o = a_i + b_i;
`endif

endmodule

// File: rtl/rect_stream_tx.sv
// Streams RECT_COUNT rect records from data memory to the GPU as absolute
// left/top/right/bottom/color words. Build macro RECT_CLIP_EN enables saturation.
//
// state  | meaning
// IDLE   | waiting for start
// START  | copy_start pulse, first read (rect 0, field x) issued
// STREAM | one read per cycle until the last field of the last rect
// DONE   | draining the last two words through the read/output pipeline
module rect_stream_tx
    import rect_stream_tx_pkg::*;
#(
    parameter int          RECT_COUNT       = 64,
    parameter int          RECT_COUNT_WIDTH = 6,
    parameter logic [15:0] RECT_BASE        = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_din,
    output logic        copy_start,
    output logic [15:0] dout,
    output logic        dout_valid,
    output logic        busy
);

    localparam logic [RECT_COUNT_WIDTH-1:0] RECT_LAST = RECT_COUNT_WIDTH'(RECT_COUNT - 1);

    state_e                      state_q, state_d;
    logic [15:0]                 addr_q;
    logic [2:0]                  rd_field_q;
    logic [RECT_COUNT_WIDTH-1:0] rect_q;
    logic                        rd_valid_q;
    logic [2:0]                  dfield_q;
    logic [15:0]                 left_q, top_q;
    logic [15:0]                 dout_q, dout_d;
    logic                        dout_valid_q;
    logic                        issue;
    logic                        last_rd;
    logic [15:0]                 add_a, add_sum;

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        last_rd = (rd_field_q == FLD_COLOR) && (rect_q == RECT_LAST);
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_START;
            end
            ST_START: begin
                issue   = 1'b1;
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                issue = 1'b1;
                if (last_rd) state_d = ST_DONE;
            end
            ST_DONE: begin
                // rd_valid_q low means the final word already moved into dout_q
                if (!rd_valid_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q     <= RECT_BASE;
            rd_field_q <= FLD_X;
            rect_q     <= '0;
        end else if (state_q == ST_IDLE && start) begin
            addr_q     <= RECT_BASE;
            rd_field_q <= FLD_X;
            rect_q     <= '0;
        end else if (issue && !last_rd) begin
            addr_q <= addr_q + 16'd1;
            if (rd_field_q == FLD_COLOR) begin
                rd_field_q <= FLD_X;
                rect_q     <= rect_q + RECT_COUNT_WIDTH'(1);
            end else begin
                rd_field_q <= rd_field_q + 3'd1;
            end
        end
    end

    assign add_a = (dfield_q == FLD_W) ? left_q : top_q;

    rect_abs_adder u_adder (
        .a_i   (add_a),
        .b_i   (mem_din),
        .sum_o (add_sum)
    );

    always_comb begin
        dout_d = mem_din;
        case (dfield_q)
            FLD_W, FLD_H: dout_d = add_sum;
            default:      dout_d = mem_din;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_valid_q   <= 1'b0;
            dfield_q     <= FLD_X;
            left_q       <= '0;
            top_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            rd_valid_q   <= issue;
            if (issue) dfield_q <= rd_field_q;
            if (rd_valid_q && dfield_q == FLD_X) left_q <= mem_din;
            if (rd_valid_q && dfield_q == FLD_Y) top_q  <= mem_din;
            dout_q       <= rd_valid_q ? dout_d : 16'h0000;
            dout_valid_q <= rd_valid_q;
        end
    end

    assign mem_addr   = addr_q;
    assign copy_start = (state_q == ST_START);
    assign busy       = (state_q != ST_IDLE);
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule
